// File: rtl/axi_write_queue_pkg.sv
// Shared types for the AXI-Lite write queue: FSM state encoding and the
// queue entry layout at the default address/data widths.
package axi_write_queue_pkg;

    localparam int WQ_ADDR_W = 32;
    localparam int WQ_DATA_W = 32;

    typedef enum logic [1:0] {
        WQ_IDLE = 2'd0,
        WQ_REQ  = 2'd1,
        WQ_GAP  = 2'd2
    } wq_state_e;

    typedef struct packed {
        logic [WQ_ADDR_W-1:0] adress;
        logic [WQ_DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/adam_seq.sv
// Sequencing bundle: single rising-edge clock plus asynchronous active-high reset.
interface ADAM_SEQ;
    logic clk;
    logic rst;

    modport Master (output clk, output rst);
    modport Slave  (input clk, input rst);
endinterface

// File: rtl/axi_write_queue_ring_fifo.sv
// Ring FIFO behind the write queue. Pointers wrap modulo DEPTH and the
// occupancy count is kept separately so full/empty are unambiguous.
// flush drops everything; flush with flush_keep_head keeps the in-flight head.
module wq_ring_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       flush_keep_head,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic             empty_r, full_r;
    logic             push_ok_s, pop_ok_s, we_s;

    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;
    assign head_data = mem_r[head_r];
    assign count     = count_r;
    assign empty     = empty_r;
    assign full      = full_r;

    // Next pointer/count computation for push, pop and the two flush flavours.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        we_s        = 1'b0;
        if (flush) begin
            if (flush_keep_head && !empty_r) begin
                if (pop_ok_s) begin
                    head_nxt_s  = head_r + 1'b1;
                    tail_nxt_s  = head_r + 1'b1;
                    count_nxt_s = '0;
                end else begin
                    tail_nxt_s  = head_r + 1'b1;
                    count_nxt_s = CNT_W'(1);
                end
            end else begin
                tail_nxt_s  = head_r;
                count_nxt_s = '0;
            end
        end else begin
            we_s = push_ok_s;
            if (push_ok_s) begin
                tail_nxt_s = tail_r + 1'b1;
            end else begin
                tail_nxt_s = tail_r;
            end
            if (pop_ok_s) begin
                head_nxt_s = head_r + 1'b1;
            end else begin
                head_nxt_s = head_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = count_r + 1'b1;
                2'b01:   count_nxt_s = count_r - 1'b1;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer, count and flag registers; flags are registered from next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == '0);
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[tail_r] <= wdata;
        end
    end

endmodule

// File: rtl/axi_write_queue.sv
// Write queue in front of the AXI-Lite write engine: buffers address/data
// requests and presents them one at a time on a req/ack port with one
// req-low cycle between transactions, plus flush, ack timeout and status.
// Optional high-water mark tracking is enabled by AXI_WRITE_QUEUE_HWM_EN.
module axi_write_queue
    import axi_write_queue_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    ADAM_SEQ.Slave                     seq_port,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [ADDR_W-1:0]          push_adress_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       flush_i,
    output logic                       wr_req_o,
    output logic [ADDR_W-1:0]          wr_adress_o,
    output logic [DATA_W-1:0]          wr_data_o,
    input  logic                       wr_ack_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       timeout_o
`ifdef AXI_WRITE_QUEUE_HWM_EN
    ,
    input  logic                       hwm_clr_i,
    output logic [$clog2(DEPTH+1)-1:0] hwm_o
`endif
);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES+1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);

    logic              clk, rst;
    wq_state_e         state_r;
    logic              wr_req_r, timeout_r;
    logic [ADDR_W-1:0] wr_adress_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [ENT_W-1:0]  head_s;
    logic              push_s, pop_s, keep_head_s, issue_s;

    assign clk = seq_port.clk;
    assign rst = seq_port.rst;

    // A push is refused while full (even if the head pops this cycle) or flushing.
    assign push_ready_o = !full_o && !flush_i;
    assign push_s       = push_valid_i && push_ready_o;
    assign pop_s        = (state_r == WQ_REQ) && wr_ack_i;
    assign keep_head_s  = (state_r == WQ_REQ);
    assign issue_s      = !empty_o && !flush_i;

    assign wr_req_o    = wr_req_r;
    assign wr_adress_o = wr_adress_r;
    assign wr_data_o   = wr_data_r;
    assign timeout_o   = timeout_r;

    wq_ring_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .push            (push_s),
        .pop             (pop_s),
        .flush           (flush_i),
        .flush_keep_head (keep_head_s),
        .wdata           ({push_adress_i, push_data_i}),
        .head_data       (head_s),
        .count           (count_o),
        .empty           (empty_o),
        .full            (full_o)
    );

    // Issue FSM with registered req, head address/data and the ack timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= WQ_IDLE;
            wr_req_r    <= 1'b0;
            wr_adress_r <= '0;
            wr_data_r   <= '0;
            tmo_cnt_r   <= '0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                WQ_IDLE, WQ_GAP: begin
                    tmo_cnt_r <= '0;
                    timeout_r <= 1'b0;
                    if (!empty_o) begin
                        wr_adress_r <= head_s[ENT_W-1:DATA_W];
                        wr_data_r   <= head_s[DATA_W-1:0];
                    end else begin
                        wr_adress_r <= wr_adress_r;
                        wr_data_r   <= wr_data_r;
                    end
                    if (issue_s) begin
                        state_r  <= WQ_REQ;
                        wr_req_r <= 1'b1;
                    end else begin
                        state_r  <= WQ_IDLE;
                        wr_req_r <= 1'b0;
                    end
                end
                WQ_REQ: begin
                    if (wr_ack_i) begin
                        state_r   <= WQ_GAP;
                        wr_req_r  <= 1'b0;
                        tmo_cnt_r <= '0;
                        timeout_r <= 1'b0;
                    end else begin
                        state_r   <= WQ_REQ;
                        wr_req_r  <= 1'b1;
                        timeout_r <= TMO_EN && (tmo_cnt_r == TMO_LAST);
                        if (TMO_EN && (tmo_cnt_r != TMO_SAT)) begin
                            tmo_cnt_r <= tmo_cnt_r + 1'b1;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r;
                        end
                    end
                end
                default: begin
                    state_r   <= WQ_IDLE;
                    wr_req_r  <= 1'b0;
                    tmo_cnt_r <= '0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXI_WRITE_QUEUE_HWM_EN
    logic [$clog2(DEPTH+1)-1:0] hwm_r;

    assign hwm_o = hwm_r;

    // High-water mark of occupancy; a clear reloads it with the current count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_r <= '0;
        end else if (hwm_clr_i) begin
            hwm_r <= count_o;
        end else if (count_o > hwm_r) begin
            hwm_r <= count_o;
        end else begin
            hwm_r <= hwm_r;
        end
    end
`endif

endmodule

// File: doc/axi_write_queue.md
Name: axi_write_queue

Overview:
- Buffering stage directly upstream of the AXI-Lite write engine.
- Accepts a burst of write requests (address + data) from a producer and holds them in a ring FIFO.
- Presents them one at a time on the engine's low-priority req/ack write port:
  - holds address/data stable until ack;
  - guarantees one req-low cycle between transactions.
- Adds flush, a per-transaction ack timeout flag, and occupancy status.

Parameters:
- DEPTH, 8, number of queue entries; power of two, >= 2
- ADDR_W, 32, write address width
- DATA_W, 32, write data width
- TIMEOUT_CYCLES, 1024, cycles in REQ without ack before timeout_o pulses; 0 disables the timeout

Ports:
- seq_port  slave (ADAM_SEQ.Slave)  -  carries clk (single clock, rising edge) and rst (asynchronous, active-high)
- push_valid_i  in  1  producer has a write request
- push_ready_o  out  1  queue can accept; = !full && !flush_i (combinational)
- push_adress_i  in  ADDR_W  request address
- push_data_i  in  DATA_W  request data
- flush_i  in  1  discard queued, not-yet-issued entries
- wr_req_o  out  1  request to write engine
- wr_adress_o  out  ADDR_W  head address
- wr_data_o  out  DATA_W  head data
- wr_ack_i  in  1  one-cycle accept pulse from write engine
- count_o  out  $clog2(DEPTH+1)  current occupancy, including the in-flight head
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == DEPTH
- timeout_o  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (seq_port.rst high, asynchronous; takes effect immediately, including mid-transaction):
  - wr_req_o=0, count_o=0, empty_o=1, full_o=0, timeout_o=0, wr_adress_o=0, wr_data_o=0
  - pointers 0, state WQ_IDLE, timeout counter 0.
- Push: entry written at tail on the edge where push_valid_i && push_ready_o. No push when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): count unchanged; both pointers advance.
- FSM (Moore, registered), wr_req_o = (state == WQ_REQ):
  - WQ_IDLE: if count > 0, go to WQ_REQ. Push at edge N means wr_req_o is high in cycle N+2.
  - WQ_REQ:
    - wr_adress_o/wr_data_o = head entry, stable for the whole state.
    - On wr_ack_i: pop head, go to WQ_GAP.
  - WQ_GAP: wr_req_o low for exactly one cycle. Then go to WQ_REQ if count > 0, else WQ_IDLE.
  - Back-to-back throughput is therefore at most one write per (engine latency + 1 gap) cycles.
- wr_ack_i outside WQ_REQ: ignored; no pop, no state change.
- wr_adress_o/wr_data_o outside WQ_REQ: show the current head, or hold the last value when empty. Do not care for the engine.
- Flush (level, sampled each edge):
  - In WQ_IDLE/WQ_GAP: count set to 0; tail set to head.
  - In WQ_REQ: all entries except the in-flight head are dropped; count set to 1; the head completes normally on ack.
  - A push is never accepted while flush_i is high.
- Timeout:
  - Counter clears on entry to WQ_REQ and increments each WQ_REQ cycle without ack.
  - timeout_o pulses once when the counter reaches TIMEOUT_CYCLES-1; the counter then saturates, so there is at most one pulse per transaction.
  - wr_req_o stays high; the transaction is never aborted.
  - An ack on the same cycle as the threshold suppresses the pulse.
- Pointer wrap: modulo DEPTH. count_o is held separately so full and empty are unambiguous.

Optional Feature:
- Macro AXI_WRITE_QUEUE_HWM_EN.
- Defined:
  - adds input hwm_clr_i (1) and output hwm_o ($clog2(DEPTH+1)).
  - hwm_o = maximum count_o since reset or since the last hwm_clr_i.
  - On a clear edge, hwm_o loads the current count_o.
  - Reset value 0.
- Undefined: both ports and the register are absent; all other behaviour is identical.

Decomposition:
- Package axi_write_queue_pkg:
  - wq_state_e {WQ_IDLE, WQ_REQ, WQ_GAP}
  - wq_entry_t struct {adress, data}, parameterised by ADDR_W/DATA_W defaults
- Sub-module wq_ring_fifo:
  - storage array, head/tail pointers, count, push/pop/flush_keep_head inputs
  - asynchronous-reset pointers, no reset on storage.
- The top level holds the FSM, the timeout counter and the optional HWM.

Test Plan:
- Single push (adress 0x1000_0000, data 0xDEAD_BEEF) into an empty queue:
  - wr_req_o high 2 cycles later with those values;
  - ack 3 cycles later, then wr_req_o low next cycle; count_o 1 -> 0, empty_o=1.
- Push 8 entries (adress 0x10..0x17) with a model engine acking 2 cycles after req:
  - full_o=1 after the 8th push; 9th push_valid_i sees push_ready_o=0;
  - issue order 0x10..0x17, each with exactly one req-low gap cycle.
- 4 entries queued, flush_i asserted while the head (0x20) is in WQ_REQ:
  - count_o=1; only 0x20 is issued after ack; queue empty after.
- TIMEOUT_CYCLES=16, engine never acks:
  - timeout_o pulses exactly once, 16 cycles after wr_req_o rise;
  - wr_req_o stays high; a late ack pops normally.
- Reset asserted mid-WQ_REQ with 3 entries:
  - wr_req_o, count_o and full_o drop immediately (asynchronous);
  - after release, no request is issued until a new push.
- With AXI_WRITE_QUEUE_HWM_EN:
  - push 5, drain, push 2 -> hwm_o=5;
  - pulse hwm_clr_i with 2 queued -> hwm_o=2.
